// File: rtl/crc_arb_pkg.sv
// Shared types and constants for the serial CRC arbiter.
// Optional feature macro: CRC_ARB_TIMEOUT_EN (bounded WAIT with abort).
package crc_arb_pkg;

  localparam int unsigned CRC_W           = 8;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned ID_W            = 2;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

  // Result payload presented on res_*.
  typedef struct packed {
    logic              err;
    logic [ID_W-1:0]   id;
    logic [CRC_W-1:0]  crc;
  } crc_res_t;

  // Index of the set bit in a one-hot vector of up to four requesters.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [3:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/crc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the requester after the last accepted one.
module crc_rr_arbiter
  import crc_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] gnt_c_o
);

  localparam int unsigned PTR_W = (N_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Rotating-priority search starting at ptr_q; pointer advances only on accept.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    gnt_c_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt_c_o[idx] = 1'b1;
        if (accept_i) begin
          ptr_d = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  // Priority pointer register; requester 0 has priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/crc_serial_arbiter.sv
// Arbitrates byte-stream frames from N_REQ requesters onto a bit-serial CRC
// engine and reports the engine result per frame.
// Optional feature macro: CRC_ARB_TIMEOUT_EN (abort WAIT after TIMEOUT_CYC cycles).
module crc_serial_arbiter
  import crc_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        s_valid,
  input  logic [BYTE_W*N_REQ-1:0] s_data,
  input  logic [N_REQ-1:0]        s_last,
  output logic [N_REQ-1:0]        s_ready,
  output logic                    crc_clr,
  output logic                    crc_din,
  output logic                    crc_din_vld,
  input  logic [CRC_W-1:0]        crc_dout,
  input  logic                    crc_dout_vld,
  output logic                    res_valid,
  output logic [CRC_W-1:0]        res_crc,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_err
);

  // TIMEOUT_CYC only sizes the optional WAIT counter; a zero value is meaningless.
  if (TIMEOUT_CYC == 0) begin : g_tmo_cfg_zero
  end

  arb_state_e            state_q, state_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic                  last_q, last_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  crc_res_t              res_q, res_d;
  logic [N_REQ-1:0]      s_ready_q, s_ready_d;
  logic                  crc_clr_q, crc_clr_d;
  logic                  crc_din_q, crc_din_d;
  logic                  crc_din_vld_q, crc_din_vld_d;
  logic                  res_valid_q, res_valid_d;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

  logic [N_REQ-1:0]      arb_gnt_c;
  logic                  arb_accept_c;
  logic [BYTE_W-1:0]     sel_byte_c;
  logic                  sel_last_c;
  logic                  xfer_c;

  crc_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (s_valid),
    .accept_i (arb_accept_c),
    .gnt_c_o  (arb_gnt_c)
  );

  // Byte and last flag of the granted requester.
  always_comb begin
    sel_byte_c = '0;
    sel_last_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_byte_c = s_data[i*BYTE_W +: BYTE_W];
        sel_last_c = s_last[i];
      end
    end
  end

  assign xfer_c = |(s_valid & s_ready_q);

  // Next state, datapath and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    byte_d       = byte_q;
    last_d       = last_q;
    bit_cnt_d    = bit_cnt_q;
    res_d        = res_q;
    arb_accept_c = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    tmo_cnt_d    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|s_valid) begin
          grant_d      = arb_gnt_c;
          arb_accept_c = 1'b1;
          state_d      = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_LOAD;
      ST_LOAD: begin
        if (xfer_c) begin
          byte_d    = sel_byte_c;
          last_d    = sel_last_c;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_CNT_W'(7)) begin
          state_d = last_q ? ST_WAIT : ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (crc_dout_vld) begin
          res_d.crc = crc_dout;
          res_d.id  = onehot_to_idx(4'(grant_q));
          res_d.err = 1'b0;
          state_d   = ST_DONE;
        end
`ifdef CRC_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          res_d.crc = '0;
          res_d.id  = onehot_to_idx(4'(grant_q));
          res_d.err = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    s_ready_d     = (state_d == ST_LOAD) ? grant_d : '0;
    crc_clr_d     = (state_d == ST_CLR);
    crc_din_vld_d = (state_d == ST_SHIFT);
    crc_din_d     = crc_din_vld_d & byte_d[BIT_CNT_W'(7) - bit_cnt_d];
    res_valid_d   = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      bit_cnt_q     <= '0;
      res_q         <= '0;
      s_ready_q     <= '0;
      crc_clr_q     <= 1'b0;
      crc_din_q     <= 1'b0;
      crc_din_vld_q <= 1'b0;
      res_valid_q   <= 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      res_q         <= res_d;
      s_ready_q     <= s_ready_d;
      crc_clr_q     <= crc_clr_d;
      crc_din_q     <= crc_din_d;
      crc_din_vld_q <= crc_din_vld_d;
      res_valid_q   <= res_valid_d;
`ifdef CRC_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign crc_clr     = crc_clr_q;
  assign crc_din     = crc_din_q;
  assign crc_din_vld = crc_din_vld_q;
  assign res_valid   = res_valid_q;
  assign res_crc     = res_q.crc;
  assign res_id      = res_q.id;
  assign res_err     = res_q.err;

endmodule

// File: tb/tb_crc_serial_arbiter.sv
// Directed bench for crc_serial_arbiter with serial-bit and result scoreboards.
// Timeout scenario is built only with CRC_ARB_TIMEOUT_EN.
module tb_crc_serial_arbiter;

  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   s_valid;
  logic [8*NR-1:0] s_data;
  logic [NR-1:0]   s_last;
  logic [NR-1:0]   s_ready;
  logic            crc_clr;
  logic            crc_din;
  logic            crc_din_vld;
  logic [7:0]      crc_dout;
  logic            crc_dout_vld;
  logic            res_valid;
  logic [7:0]      res_crc;
  logic [1:0]      res_id;
  logic            res_err;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  int clr_cnt = 0;

  logic        bitq[$];
  logic [10:0] resq[$];
  logic [10:0] exp_res;

  always #5 clk = ~clk;

  crc_serial_arbiter #(.N_REQ(NR), .TIMEOUT_CYC(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .crc_clr      (crc_clr),
    .crc_din      (crc_din),
    .crc_din_vld  (crc_din_vld),
    .crc_dout     (crc_dout),
    .crc_dout_vld (crc_dout_vld),
    .res_valid    (res_valid),
    .res_crc      (res_crc),
    .res_id       (res_id),
    .res_err      (res_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) bitq.push_back(b[k]);
  endtask

  // Present a byte on requester i and complete the handshake; returns one
  // negedge after the transfer edge with s_valid[i] dropped.
  task automatic send_byte(input int i, input logic [7:0] b, input logic l);
    int n;
    s_valid[i] = 1'b1;
    s_data[8*i +: 8] = b;
    s_last[i] = l;
    n = 0;
    while (!s_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_grant", 32'(s_ready), 32'(1 << i));
    push_bits(b);
    @(negedge clk);
    s_valid[i] = 1'b0;
    chk("shift_start", 32'(crc_din_vld), 32'd1);
  endtask

  // Wait for the serial stream of the frame to drain (WAIT entered).
  task automatic wait_wait();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((crc_din_vld || bitq.size() != 0) && n < 200);
    chk("reach_wait", 32'(crc_din_vld), 32'd0);
    chk("bits_left", 32'(bitq.size()), 32'd0);
  endtask

  task automatic respond(input logic [7:0] v, input logic [1:0] id);
    resq.push_back({1'b0, id, v});
    crc_dout = v;
    crc_dout_vld = 1'b1;
    @(negedge clk);
    crc_dout_vld = 1'b0;
    chk("res_valid", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("res_pulse", 32'(res_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = '0;
    s_last = '0;
    crc_dout_vld = 1'b0;
    bitq.delete();
    resq.delete();
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({s_ready, crc_clr, crc_din, crc_din_vld, res_valid, res_id, res_err}), 32'd0);
    chk("rst_crc", 32'(res_crc), 32'd0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitors: serial bits and frame results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (crc_din_vld) begin
        vld_cnt++;
        chk("bit_expected", 32'(bitq.size() != 0), 32'd1);
        if (bitq.size() != 0) chk("crc_din", 32'(crc_din), 32'(bitq.pop_front()));
      end else begin
        chk("din_quiet", 32'(crc_din), 32'd0);
      end
      if (crc_clr) clr_cnt++;
      if (res_valid) begin
        chk("res_expected", 32'(resq.size() != 0), 32'd1);
        if (resq.size() != 0) begin
          exp_res = resq.pop_front();
          chk("res_crc", 32'(res_crc), 32'(exp_res[7:0]));
          chk("res_id", 32'(res_id), 32'(exp_res[9:8]));
          chk("res_err", 32'(res_err), 32'(exp_res[10]));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, n;
    s_valid = '0;
    s_data = '0;
    s_last = '0;
    crc_dout = '0;
    crc_dout_vld = 1'b0;
    @(negedge clk);
    do_reset();

    // Engine result strobe in IDLE must be ignored.
    crc_dout = 8'h99;
    crc_dout_vld = 1'b1;
    repeat (2) @(negedge clk);
    crc_dout_vld = 1'b0;
    chk("idle_ignore_vld", 32'(res_valid), 32'd0);

    // Single byte 0xAB from req0, exact minimum latency.
    c0 = clr_cnt;
    v0 = vld_cnt;
    s_valid[0] = 1'b1;
    s_data[7:0] = 8'hAB;
    s_last[0] = 1'b1;
    push_bits(8'hAB);
    @(negedge clk);
    chk("t1_clr", 32'(crc_clr), 32'd1);
    chk("t1_rdy_in_clr", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("t1_clr_once", 32'(crc_clr), 32'd0);
    chk("t1_rdy", 32'(s_ready), 32'b01);
    @(negedge clk);
    s_valid[0] = 1'b0;
    chk("t1_vld", 32'(crc_din_vld), 32'd1);
    chk("t1_rdy_drop", 32'(s_ready), 32'd0);
    repeat (7) @(negedge clk);
    chk("t1_vld_8th", 32'(crc_din_vld), 32'd1);
    @(negedge clk);
    chk("t1_wait", 32'(crc_din_vld), 32'd0);
    chk("t1_bits", 32'(vld_cnt - v0), 32'd8);
    chk("t1_clr_cnt", 32'(clr_cnt - c0), 32'd1);
    respond(8'h5C, 2'd0);
    repeat (3) @(negedge clk);
    chk("t1_hold_crc", 32'(res_crc), 32'h5C);
    chk("t1_hold_id", 32'(res_id), 32'd0);

    // Simultaneous requests after reset: req0 then req1.
    do_reset();
    s_valid = 2'b11;
    s_data = {8'h22, 8'h11};
    s_last = 2'b11;
    send_byte(0, 8'h11, 1'b1);
    wait_wait();
    respond(8'h3C, 2'd0);
    send_byte(1, 8'h22, 1'b1);
    wait_wait();
    respond(8'hC3, 2'd1);
    chk("t2_hold_id", 32'(res_id), 32'd1);

    // Two bytes from req1 with an input gap while LOAD waits.
    c0 = clr_cnt;
    v0 = vld_cnt;
    send_byte(1, 8'h0A, 1'b0);
    n = 0;
    while (!s_ready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_load", 32'(s_ready), 32'b10);
    crc_dout = 8'h99;
    crc_dout_vld = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      crc_dout_vld = 1'b0;
      chk("t3_gap_vld", 32'(crc_din_vld), 32'd0);
      chk("t3_gap_rdy", 32'(s_ready), 32'b10);
    end
    send_byte(1, 8'hB0, 1'b1);
    wait_wait();
    chk("t3_bits", 32'(vld_cnt - v0), 32'd16);
    chk("t3_clr_cnt", 32'(clr_cnt - c0), 32'd1);
    respond(8'h77, 2'd1);

    // Reset during SHIFT of byte 2 abandons the frame.
    send_byte(0, 8'h12, 1'b0);
    send_byte(0, 8'h34, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bitq.delete();
    @(negedge clk);
    chk("t4_rst_outs", 32'({s_ready, crc_clr, crc_din, crc_din_vld, res_valid}), 32'd0);
    chk("t4_rst_crc", 32'(res_crc), 32'd0);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("t4_no_res", 32'(res_valid), 32'd0);
    end
    c0 = clr_cnt;
    s_valid = 2'b11;
    s_data = {8'hA5, 8'h5A};
    s_last = 2'b11;
    @(negedge clk);
    chk("t4_clr", 32'(crc_clr), 32'd1);
    send_byte(0, 8'h5A, 1'b1);
    wait_wait();
    respond(8'hE1, 2'd0);
    chk("t4_clr_cnt", 32'(clr_cnt - c0), 32'd1);
    send_byte(1, 8'hA5, 1'b1);
    wait_wait();
    respond(8'h1E, 2'd1);

`ifdef CRC_ARB_TIMEOUT_EN
    // Engine never answers: abort exactly 64 cycles after WAIT entry.
    send_byte(0, 8'hFF, 1'b1);
    wait_wait();
    resq.push_back({1'b1, 2'd0, 8'h00});
    for (int g = 0; g < 63; g++) begin
      @(negedge clk);
      chk("t5_no_early", 32'(res_valid), 32'd0);
    end
    @(negedge clk);
    chk("t5_timeout", 32'(res_valid), 32'd1);
    chk("t5_err", 32'(res_err), 32'd1);
    chk("t5_crc", 32'(res_crc), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("end_resq_empty", 32'(resq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
